spi_receptor: RTL and testbench
===============================

# spi_receptor

SPI slave receiver/transmitter that sits directly downstream of the team's SPI master (transmitter). It consumes SCK, SS and MOSI from the master and returns MISO. It supports all four CKP/CPH modes and delivers each received WIDTH-bit word on a parallel port with a one-cycle valid strobe. SCK is oversampled by the system clock, so the block is fully synchronous to CLK.

## Interface
- WIDTH, 16: bits per frame, MSB first; legal range 2..32.
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- CKP  input  1  clock polarity: SCK idle level.
- CPH  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- SCK  input  1  serial clock from the master.
- SS  input  1  slave select, active-low.
- MOSI  input  1  serial data from the master.
- TX_DATA  input  WIDTH  word to return on MISO; captured at frame start.
- MISO  output  1  serial data to the master.
- RX_DATA  output  WIDTH  last complete received word.
- RX_VALID  output  1  one-cycle pulse: RX_DATA updated.
- BUSY  output  1  high while a frame is in progress.
- FRAME_ERR  output  1  one-cycle pulse: frame aborted by early SS rise.

## Operation
- Input path: SCK, SS and MOSI pass through the input stage (see Configuration). Edges are detected by comparing the stage output with its value one cycle earlier.
- Leading edge = SCK leaving CKP. Trailing edge = SCK returning to CKP.
- CPH=0: sample on leading edge, shift MISO on trailing edge. CPH=1: shift on leading edge, sample on trailing edge.
- CKP and CPH are latched at SS fall. Changes during a frame are ignored.
- States:
  - IDLE: SS high; BUSY=0; MISO=0. SS fall detected -> load TX_DATA into the tx shift register, clear the bit counter, go to ACTIVE.
  - ACTIVE: BUSY=1.
    - CPH=0: MISO = TX_DATA MSB from entry.
    - CPH=1: the first shift edge presents the MSB.
    - Each sample edge shifts MOSI into the rx register LSB and increments the counter.
    - The WIDTH-th sample -> copy to RX_DATA, pulse RX_VALID, go to DONE.
  - DONE: BUSY=1. SCK edges are ignored and MISO holds its last bit. SS rise -> IDLE.
- SS rise in ACTIVE with counter < WIDTH: pulse FRAME_ERR, RX_DATA unchanged, no RX_VALID, go to IDLE.
- SS fall in the same cycle as a detected SCK edge: the SCK edge is ignored.
- Counter width: clog2(WIDTH+1). It never wraps, because the WIDTH-th sample exits ACTIVE.
- RESET in any state: all registers cleared, state IDLE, next cycle. A frame interrupted by reset is dropped silently (no FRAME_ERR).

## Timing
- Reset values: MISO=0, RX_DATA=0, RX_VALID=0, BUSY=0, FRAME_ERR=0.
- D = input-stage delay: 3 CLK with the macro, 1 CLK without.
- A pin edge is detected in cycle D after that edge.
- RX_VALID, FRAME_ERR, BUSY and MISO change in cycle D+1 after the causing pin edge.
- Master constraint: SCK high and low phases each ≥ 8 CLK cycles. SS setup before the first SCK edge ≥ 8 CLK cycles.
- Back-to-back frames: SS high ≥ D+2 cycles between frames.

## Configuration
- SPI_RECEPTOR_SYNC_EN defined: SCK, SS and MOSI each pass through a 2-flop synchronizer followed by the edge-detect register (D=3). Use this for asynchronous masters.
- Undefined: a single register stage only (D=1). Legal only when the master is clocked by CLK.
- Function is identical either way; only latency differs.

## Test plan
- Mode 0 (CKP=0, CPH=0), TX_DATA=16'hA5C3, master sends 16'h3C5A -> RX_DATA=16'h3C5A with one RX_VALID pulse; master captures 16'hA5C3 on MISO.
- Modes 1, 2, 3 repeated with MOSI 16'hFFFF then 16'h0001 -> RX_DATA matches each word. MISO bits are stable at every master sample edge.
- SS raised after 7 SCK pulses -> FRAME_ERR pulses once, RX_VALID stays 0, RX_DATA keeps its previous value, BUSY=0 D+1 cycles after SS rise.
- 20 SCK pulses in a single SS-low window -> exactly one RX_VALID, after pulse 16. Pulses 17-20 change nothing.
- RESET asserted mid-frame (bit 9) -> next cycle all outputs 0, state IDLE. A following full frame 16'h1234 is received correctly.
- CKP toggled mid-frame in mode 0 -> frame still decoded using the latched mode. Run both with and without SPI_RECEPTOR_SYNC_EN and check the RX_VALID latency (D+1).

Source files
------------

// File: rtl/spi_receptor.sv
// SPI slave receiver/transmitter, all four CKP/CPH modes, oversampled by CLK.
// Optional SPI_RECEPTOR_SYNC_EN adds a 2-flop synchronizer ahead of the edge-detect stage.
module spi_receptor #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             SS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             MISO,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SPI_RECEPTOR_SYNC_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  // Bit STAGES-1 is the stage output; bit STAGES is its value one cycle earlier.
  logic [STAGES:0]   sck_pipe_q, sck_pipe_d;
  logic [STAGES:0]   ss_pipe_q, ss_pipe_d;
  logic [STAGES-1:0] mosi_pipe_q, mosi_pipe_d;

  state_t            state_q, state_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;

  logic sck_s, sck_p, ss_s, ss_p, mosi_s;
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sck_pipe_d  = {sck_pipe_q[STAGES-1:0], SCK};
    ss_pipe_d   = {ss_pipe_q[STAGES-1:0], SS};
`ifdef SPI_RECEPTOR_SYNC_EN
    mosi_pipe_d = {mosi_pipe_q[STAGES-2:0], MOSI};
`else
    mosi_pipe_d = MOSI;
`endif
  end

  assign sck_s  = sck_pipe_q[STAGES-1];
  assign sck_p  = sck_pipe_q[STAGES];
  assign ss_s   = ss_pipe_q[STAGES-1];
  assign ss_p   = ss_pipe_q[STAGES];
  assign mosi_s = mosi_pipe_q[STAGES-1];

  assign sck_edge    = sck_s ^ sck_p;
  assign lead_edge   = sck_edge && (sck_p == ckp_q);
  assign trail_edge  = sck_edge && (sck_s == ckp_q);
  assign sample_edge = cph_q ? trail_edge : lead_edge;
  assign shift_edge  = cph_q ? lead_edge : trail_edge;
  assign ss_fall     = ss_p && !ss_s;
  assign ss_rise     = !ss_p && ss_s;

  always_comb begin
    state_d     = state_q;
    ckp_d       = ckp_q;
    cph_d       = cph_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = miso_q;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        // SCK edges coinciding with SS fall are dropped simply by not looking at them here.
        if (ss_fall) begin
          ckp_d   = CKP;
          cph_d   = CPH;
          cnt_d   = '0;
          state_d = S_ACTIVE;
          if (!CPH) begin
            miso_d = TX_DATA[WIDTH-1];
            tx_d   = {TX_DATA[WIDTH-2:0], 1'b0};
          end else begin
            tx_d   = TX_DATA;
          end
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          if (sample_edge) begin
            rx_d  = {rx_q[WIDTH-2:0], mosi_s};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              rx_data_d  = {rx_q[WIDTH-2:0], mosi_s};
              rx_valid_d = 1'b1;
              state_d    = S_DONE;
            end
          end
          if (shift_edge) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        if (ss_rise) begin
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_pipe_q  <= '0;
      ss_pipe_q   <= '0;
      mosi_pipe_q <= '0;
      state_q     <= S_IDLE;
      ckp_q       <= 1'b0;
      cph_q       <= 1'b0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_pipe_q  <= sck_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      state_q     <= state_d;
      ckp_q       <= ckp_d;
      cph_q       <= cph_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign BUSY      = (state_q != S_IDLE);
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_receptor.sv
// Randomized scoreboard bench for spi_receptor: a master model drives frames and
// checks MISO; a monitor pops expected RX_VALID/FRAME_ERR events as they appear.
module tb_spi_receptor;

  localparam int W    = 16;
  localparam int HALF = 8;
`ifdef SPI_RECEPTOR_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic         CLK = 1'b0;
  logic         RESET, CKP, CPH, SCK, SS, MOSI;
  logic [W-1:0] TX_DATA;
  logic         MISO, RX_VALID, BUSY, FRAME_ERR;
  logic [W-1:0] RX_DATA;

  spi_receptor #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .SS(SS),
    .MOSI(MOSI), .TX_DATA(TX_DATA), .MISO(MISO), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           edge_cyc = 0;
  logic [W-1:0] model_rx = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic word_bit(input logic [W-1:0] w, input int idx);
    if (idx < W) return w[W-1-idx];
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge CLK) begin
    if (!RESET && (RX_VALID || FRAME_ERR)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, RX_VALID, FRAME_ERR}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {30'd0, RX_VALID, FRAME_ERR}, e.err ? 32'd1 : 32'd2);
        check("rx_data", RX_DATA, e.data);
        if (!e.err) check("valid_latency", cyc - edge_cyc, D + 1);
      end
    end
  end

  // One SS-low window of np SCK pulses; optional reset after 9 pulses, optional CKP toggle.
  task automatic frame(input bit ckp, input bit cph, input logic [W-1:0] mw,
                       input logic [W-1:0] tw, input int np, input bit do_rst,
                       input bit tog);
    CKP = ckp; CPH = cph; SCK = ckp; TX_DATA = tw; MOSI = 1'b0;
    repeat (4) @(negedge CLK);
    if (!do_rst) begin
      if (np >= W) begin
        sb.push_back('{err: 1'b0, data: mw});
        model_rx = mw;
      end else begin
        sb.push_back('{err: 1'b1, data: model_rx});
      end
    end
    SS = 1'b0;
    MOSI = word_bit(mw, 0);
    repeat (HALF) @(negedge CLK);
    for (int i = 0; i < np; i++) begin
      if (!cph) begin
        SCK = ~ckp;
        if (i < W) check($sformatf("miso_bit%0d", i), MISO, tw[W-1-i]);
        if (i == W - 1) edge_cyc = cyc;
        repeat (HALF) @(negedge CLK);
        SCK = ckp;
        MOSI = word_bit(mw, i + 1);
        repeat (HALF) @(negedge CLK);
      end else begin
        SCK = ~ckp;
        MOSI = word_bit(mw, i);
        repeat (HALF) @(negedge CLK);
        SCK = ckp;
        if (i < W) check($sformatf("miso_bit%0d", i), MISO, tw[W-1-i]);
        if (i == W - 1) edge_cyc = cyc;
        repeat (HALF) @(negedge CLK);
      end
      if (tog && i == 7) CKP = ~CKP;
      if (do_rst && i == 8) break;
    end
    if (do_rst) begin
      RESET = 1'b1;
      @(negedge CLK);
      check("reset_mid_frame", {MISO, RX_DATA, RX_VALID, BUSY, FRAME_ERR}, 32'd0);
      RESET = 1'b0;
      model_rx = '0;
      SS = 1'b1;
      repeat (D + 4) @(negedge CLK);
      check("idle_after_reset", BUSY, 1'b0);
    end else begin
      SS = 1'b1;
      repeat (D) @(negedge CLK);
      check("busy_before_exit", BUSY, 1'b1);
      @(negedge CLK);
      check("busy_after_exit", BUSY, 1'b0);
      repeat (D + 3) @(negedge CLK);
    end
  endtask

  initial begin
    RESET = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    TX_DATA = '0;
    repeat (3) @(negedge CLK);
    check("reset_state", {MISO, RX_DATA, RX_VALID, BUSY, FRAME_ERR}, 32'd0);
    RESET = 1'b0;
    repeat (D + 4) @(negedge CLK);

    frame(1'b0, 1'b0, 16'h3C5A, 16'hA5C3, W, 1'b0, 1'b0);
    for (int m = 1; m < 4; m++) begin
      frame(m[1], m[0], 16'hFFFF, W'($urandom), W, 1'b0, 1'b0);
      frame(m[1], m[0], 16'h0001, W'($urandom), W, 1'b0, 1'b0);
    end
    frame(1'b0, 1'b0, W'($urandom), W'($urandom), 7, 1'b0, 1'b0);
    frame(1'b1, 1'b1, W'($urandom), W'($urandom), 20, 1'b0, 1'b0);
    frame(1'b0, 1'b0, W'($urandom), W'($urandom), W, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 16'h1234, W'($urandom), W, 1'b0, 1'b0);
    frame(1'b0, 1'b0, W'($urandom), W'($urandom), W, 1'b0, 1'b1);

    for (int k = 0; k < 12; k++) begin
      int np;
      np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W + 4)) : W;
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            W'($urandom), W'($urandom), np, 1'b0, 1'b0);
    end

    repeat (20) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
